// File: rtl/nec_prefetch_if.sv
// Bus-side handshake bundle for the NEC prefetch unit.
// A single transaction is held stable on this bus from bus_req until bus_ack.
interface nec_prefetch_if;
    logic        bus_req;
    logic [19:0] bus_addr;
    logic        bus_we;
    logic [1:0]  bus_be;
    logic [15:0] bus_wdata;
    logic        bus_ack;
    logic [15:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_addr,
        output bus_we,
        output bus_be,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_addr,
        input  bus_we,
        input  bus_be,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/nec_prefetch.sv
// 8-byte instruction prefetch queue sharing one bus with execution-unit data accesses.
// EU accesses take priority in IDLE; prefetch fills the queue a word (or odd byte) at a time.
module nec_prefetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [15:0] ps,
    input  logic        flush,
    input  logic [15:0] flush_pc,
    input  logic [3:0]  consume,
    output logic [7:0]  ipq [8],
    output logic [3:0]  ipq_len,
    input  logic        eu_req,
    input  logic [19:0] eu_addr,
    input  logic        eu_we,
    input  logic [1:0]  eu_be,
    input  logic [15:0] eu_wdata,
    output logic        eu_ack,
    output logic [15:0] eu_rdata,
    nec_prefetch_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EU
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] head_pc;
    logic [15:0] fetch_pc;
    logic        discard;
    logic [3:0]  free_space;
    logic        start_eu;
    logic        start_fetch;
    logic        fetch_done;
    logic        eu_done;
    logic        fetch_keep;

    // Queue occupancy is implied by the two PCs; it never exceeds 8 so the low nibble suffices.
    assign ipq_len     = fetch_pc[3:0] - head_pc[3:0];
    assign free_space  = 4'd8 - ipq_len;
    assign bus.bus_req = (state != IDLE);
    assign fetch_keep  = fetch_done && !discard && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_next;
        end
    end

    // eu_ack high means the EU still shows its old request this cycle, so it must not relaunch.
    always_comb begin
        state_next  = state;
        start_eu    = 1'b0;
        start_fetch = 1'b0;
        fetch_done  = 1'b0;
        eu_done     = 1'b0;
        case (state)
            IDLE: begin
                if (eu_req && !eu_ack) begin
                    start_eu   = 1'b1;
                    state_next = EU;
                end else if (!flush &&
                             ((free_space >= 4'd2) || (fetch_pc[0] && (free_space >= 4'd1)))) begin
                    start_fetch = 1'b1;
                    state_next  = FETCH;
                end
            end
            FETCH: begin
                if (bus.bus_ack) begin
                    fetch_done = 1'b1;
                    state_next = IDLE;
                end
            end
            EU: begin
                if (bus.bus_ack) begin
                    eu_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_pc       <= 16'h0000;
            fetch_pc      <= 16'h0000;
            discard       <= 1'b0;
            eu_ack        <= 1'b0;
            eu_rdata      <= 16'h0000;
            bus.bus_addr  <= 20'h00000;
            bus.bus_we    <= 1'b0;
            bus.bus_be    <= 2'b00;
            bus.bus_wdata <= 16'h0000;
        end else if (ce) begin
            eu_ack <= eu_done;
            if (eu_done) begin
                eu_rdata <= bus.bus_rdata;
            end

            if (start_eu) begin
                bus.bus_addr  <= eu_addr;
                bus.bus_we    <= eu_we;
                bus.bus_be    <= eu_be;
                bus.bus_wdata <= eu_wdata;
            end else if (start_fetch) begin
                bus.bus_addr  <= {ps, 4'h0} + {4'h0, fetch_pc};
                bus.bus_we    <= 1'b0;
                bus.bus_be    <= fetch_pc[0] ? 2'b10 : 2'b11;
                bus.bus_wdata <= 16'h0000;
            end

            if (flush) begin
                head_pc  <= flush_pc;
                fetch_pc <= flush_pc;
            end else begin
                head_pc <= head_pc + {12'h000, consume};
                if (fetch_keep) begin
                    fetch_pc <= fetch_pc + (bus.bus_be[0] ? 16'd2 : 16'd1);
                end
            end

            // A prefetch overtaken by a flush still finishes on the bus but its data is stale.
            if (fetch_done) begin
                discard <= 1'b0;
            end else if (flush && (state == FETCH)) begin
                discard <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && ce && fetch_keep) begin
            if (bus.bus_be[0]) begin
                ipq[fetch_pc[2:0]]        <= bus.bus_rdata[7:0];
                ipq[fetch_pc[2:0] + 3'd1] <= bus.bus_rdata[15:8];
            end else begin
                ipq[fetch_pc[2:0]] <= bus.bus_rdata[15:8];
            end
        end
    end

endmodule

// File: tb/tb_nec_prefetch.sv
// Directed testbench for nec_prefetch; each task drives one scenario and checks inline.
module tb_nec_prefetch;

    logic        clk;
    logic        reset;
    logic        ce;
    logic [15:0] ps;
    logic        flush;
    logic [15:0] flush_pc;
    logic [3:0]  consume;
    logic [7:0]  ipq [8];
    logic [3:0]  ipq_len;
    logic        eu_req;
    logic [19:0] eu_addr;
    logic        eu_we;
    logic [1:0]  eu_be;
    logic [15:0] eu_wdata;
    logic        eu_ack;
    logic [15:0] eu_rdata;

    int checks = 0;
    int errors = 0;

    nec_prefetch_if bus ();

    nec_prefetch dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .ps       (ps),
        .flush    (flush),
        .flush_pc (flush_pc),
        .consume  (consume),
        .ipq      (ipq),
        .ipq_len  (ipq_len),
        .eu_req   (eu_req),
        .eu_addr  (eu_addr),
        .eu_we    (eu_we),
        .eu_be    (eu_be),
        .eu_wdata (eu_wdata),
        .eu_ack   (eu_ack),
        .eu_rdata (eu_rdata),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ce = 1'b1;
        flush = 1'b0;
        consume = 4'd0;
        eu_req = 1'b0;
        bus.bus_ack = 1'b0;
        bus.bus_rdata = 16'h0000;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic do_flush(input logic [15:0] pc);
        flush = 1'b1;
        flush_pc = pc;
        step();
        flush = 1'b0;
    endtask

    task automatic wait_req(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (bus.bus_req === 1'b1) begin
                got = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic ack_bus(input logic [15:0] data);
        bus.bus_ack = 1'b1;
        bus.bus_rdata = data;
        step();
        bus.bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ce = 1'b1;
        step();
        step();
        checks++; if (ipq_len !== 4'd0) begin errors++; $display("[TB] FAIL reset_len: got %0d expected 0", ipq_len); end
        checks++; if (bus.bus_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", bus.bus_req); end
        checks++; if (bus.bus_addr !== 20'h00000) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 00000", bus.bus_addr); end
        checks++; if (bus.bus_be !== 2'b00) begin errors++; $display("[TB] FAIL reset_be: got %b expected 00", bus.bus_be); end
        checks++; if (eu_ack !== 1'b0 || eu_rdata !== 16'h0000) begin errors++; $display("[TB] FAIL reset_eu: got %b/%h expected 0/0000", eu_ack, eu_rdata); end
    endtask

    task automatic test_ps_wrap();
        bit got;
        bit seen_req;
        logic [7:0] b;
        ps = 16'hFFFF;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            wait_req(10, got);
            checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL fill_req%0d: got %b expected 1", k, got); end
            checks++; if (bus.bus_addr !== 20'hFFFF0 + 20'(2 * k)) begin errors++; $display("[TB] FAIL fill_addr%0d: got %h expected %h", k, bus.bus_addr, 20'hFFFF0 + 20'(2 * k)); end
            checks++; if (bus.bus_be !== 2'b11 || bus.bus_we !== 1'b0) begin errors++; $display("[TB] FAIL fill_ctl%0d: got be=%b we=%b expected be=11 we=0", k, bus.bus_be, bus.bus_we); end
            step();
            b = 8'hA0 + 8'(2 * k);
            ack_bus({b + 8'd1, b});
            checks++; if (ipq_len !== 4'(2 * k + 2)) begin errors++; $display("[TB] FAIL fill_len%0d: got %0d expected %0d", k, ipq_len, 2 * k + 2); end
        end
        seen_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.bus_req !== 1'b0) seen_req = 1'b1;
            step();
        end
        checks++; if (seen_req !== 1'b0) begin errors++; $display("[TB] FAIL full_stall: got req=%b expected 0", seen_req); end
        checks++; if (ipq[0] !== 8'hA0 || ipq[7] !== 8'hA7) begin errors++; $display("[TB] FAIL fill_data: got %h/%h expected a0/a7", ipq[0], ipq[7]); end
    endtask

    task automatic test_odd_flush();
        bit got;
        ps = 16'h0000;
        do_reset();
        do_flush(16'h0003);
        wait_req(10, got);
        checks++; if (got !== 1'b1 || bus.bus_addr !== 20'h00003) begin errors++; $display("[TB] FAIL odd_addr: got %b/%h expected 1/00003", got, bus.bus_addr); end
        checks++; if (bus.bus_be !== 2'b10) begin errors++; $display("[TB] FAIL odd_be: got %b expected 10", bus.bus_be); end
        ack_bus(16'hBEEF);
        checks++; if (ipq_len !== 4'd1 || ipq[3] !== 8'hBE) begin errors++; $display("[TB] FAIL odd_data: got len=%0d ipq3=%h expected 1/be", ipq_len, ipq[3]); end
        wait_req(10, got);
        checks++; if (got !== 1'b1 || bus.bus_addr !== 20'h00004 || bus.bus_be !== 2'b11) begin errors++; $display("[TB] FAIL odd_next: got %h/%b expected 00004/11", bus.bus_addr, bus.bus_be); end
        ack_bus(16'h0000);
    endtask

    task automatic test_eu_priority();
        bit got;
        ps = 16'h0000;
        do_reset();
        eu_req = 1'b1;
        eu_addr = 20'h12345;
        eu_we = 1'b1;
        eu_be = 2'b01;
        eu_wdata = 16'hABCD;
        step();
        checks++; if (bus.bus_req !== 1'b1 || bus.bus_addr !== 20'h12345) begin errors++; $display("[TB] FAIL eu_addr: got %b/%h expected 1/12345", bus.bus_req, bus.bus_addr); end
        checks++; if (bus.bus_we !== 1'b1 || bus.bus_be !== 2'b01 || bus.bus_wdata !== 16'hABCD) begin errors++; $display("[TB] FAIL eu_ctl: got %b/%b/%h expected 1/01/abcd", bus.bus_we, bus.bus_be, bus.bus_wdata); end
        step();
        checks++; if (eu_ack !== 1'b0) begin errors++; $display("[TB] FAIL eu_early: got %b expected 0", eu_ack); end
        ack_bus(16'h1234);
        eu_req = 1'b0;
        checks++; if (eu_ack !== 1'b1 || eu_rdata !== 16'h1234) begin errors++; $display("[TB] FAIL eu_ack: got %b/%h expected 1/1234", eu_ack, eu_rdata); end
        checks++; if (bus.bus_req !== 1'b0) begin errors++; $display("[TB] FAIL eu_gap: got %b expected 0", bus.bus_req); end
        step();
        checks++; if (eu_ack !== 1'b0) begin errors++; $display("[TB] FAIL eu_pulse: got %b expected 0", eu_ack); end
        wait_req(10, got);
        checks++; if (got !== 1'b1 || bus.bus_addr !== 20'h00000 || bus.bus_we !== 1'b0 || bus.bus_be !== 2'b11) begin errors++; $display("[TB] FAIL eu_then_fetch: got %h/%b/%b expected 00000/0/11", bus.bus_addr, bus.bus_we, bus.bus_be); end
        ack_bus(16'h0000);
    endtask

    task automatic test_flush_inflight();
        bit got;
        ps = 16'h0000;
        do_reset();
        do_flush(16'h0010);
        wait_req(10, got);
        checks++; if (got !== 1'b1 || bus.bus_addr !== 20'h00010) begin errors++; $display("[TB] FAIL fl_addr: got %h expected 00010", bus.bus_addr); end
        do_flush(16'h0040);
        checks++; if (ipq_len !== 4'd0 || bus.bus_req !== 1'b1) begin errors++; $display("[TB] FAIL fl_hold: got len=%0d req=%b expected 0/1", ipq_len, bus.bus_req); end
        ack_bus(16'h5555);
        checks++; if (ipq_len !== 4'd0) begin errors++; $display("[TB] FAIL fl_drop: got %0d expected 0", ipq_len); end
        wait_req(10, got);
        checks++; if (got !== 1'b1 || bus.bus_addr !== 20'h00040) begin errors++; $display("[TB] FAIL fl_next: got %h expected 00040", bus.bus_addr); end
        ack_bus(16'h0000);
    endtask

    task automatic test_consume_overlap();
        bit got;
        ps = 16'h0000;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            wait_req(10, got);
            ack_bus(16'h1111);
        end
        checks++; if (ipq_len !== 4'd6) begin errors++; $display("[TB] FAIL co_pre: got %0d expected 6", ipq_len); end
        wait_req(10, got);
        checks++; if (got !== 1'b1 || bus.bus_addr !== 20'h00006) begin errors++; $display("[TB] FAIL co_addr: got %h expected 00006", bus.bus_addr); end
        bus.bus_ack = 1'b1;
        bus.bus_rdata = 16'h7766;
        consume = 4'd3;
        step();
        bus.bus_ack = 1'b0;
        consume = 4'd0;
        checks++; if (ipq_len !== 4'd5) begin errors++; $display("[TB] FAIL co_len: got %0d expected 5", ipq_len); end
        checks++; if (ipq[6] !== 8'h66 || ipq[7] !== 8'h77) begin errors++; $display("[TB] FAIL co_data: got %h/%h expected 66/77", ipq[6], ipq[7]); end
        wait_req(10, got);
        checks++; if (got !== 1'b1 || bus.bus_addr !== 20'h00008) begin errors++; $display("[TB] FAIL co_next: got %h expected 00008", bus.bus_addr); end
        ack_bus(16'h0000);
    endtask

    task automatic test_pc_wrap();
        bit got;
        ps = 16'h1000;
        do_reset();
        do_flush(16'hFFFE);
        wait_req(10, got);
        checks++; if (got !== 1'b1 || bus.bus_addr !== 20'h1FFFE) begin errors++; $display("[TB] FAIL wrap_addr: got %h expected 1fffe", bus.bus_addr); end
        ack_bus(16'h2211);
        checks++; if (ipq_len !== 4'd2 || ipq[6] !== 8'h11 || ipq[7] !== 8'h22) begin errors++; $display("[TB] FAIL wrap_len: got %0d %h/%h expected 2 11/22", ipq_len, ipq[6], ipq[7]); end
        wait_req(10, got);
        checks++; if (got !== 1'b1 || bus.bus_addr !== 20'h10000) begin errors++; $display("[TB] FAIL wrap_next: got %h expected 10000", bus.bus_addr); end
        ack_bus(16'h0000);
    endtask

    task automatic test_ce_hold();
        bit got;
        ps = 16'h0000;
        do_reset();
        wait_req(10, got);
        ce = 1'b0;
        ack_bus(16'h4444);
        checks++; if (ipq_len !== 4'd0 || bus.bus_req !== 1'b1) begin errors++; $display("[TB] FAIL ce_ignore: got len=%0d req=%b expected 0/1", ipq_len, bus.bus_req); end
        ce = 1'b1;
        step();
        ack_bus(16'h4444);
        checks++; if (ipq_len !== 4'd2) begin errors++; $display("[TB] FAIL ce_resume: got %0d expected 2", ipq_len); end
    endtask

    task automatic test_reset_midtx();
        bit got;
        ps = 16'h0000;
        do_reset();
        do_flush(16'h0020);
        wait_req(10, got);
        checks++; if (got !== 1'b1 || bus.bus_addr !== 20'h00020) begin errors++; $display("[TB] FAIL rm_addr: got %h expected 00020", bus.bus_addr); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (bus.bus_req !== 1'b0) begin errors++; $display("[TB] FAIL rm_req: got %b expected 0", bus.bus_req); end
        ack_bus(16'h9999);
        checks++; if (ipq_len !== 4'd0 || bus.bus_addr !== 20'h00000) begin errors++; $display("[TB] FAIL rm_stray: got len=%0d addr=%h expected 0/00000", ipq_len, bus.bus_addr); end
        ack_bus(16'h0000);
    endtask

    initial begin
        reset = 1'b1;
        ce = 1'b1;
        ps = 16'h0000;
        flush = 1'b0;
        flush_pc = 16'h0000;
        consume = 4'd0;
        eu_req = 1'b0;
        eu_addr = 20'h00000;
        eu_we = 1'b0;
        eu_be = 2'b00;
        eu_wdata = 16'h0000;
        bus.bus_ack = 1'b0;
        bus.bus_rdata = 16'h0000;

        test_reset();
        test_ps_wrap();
        test_odd_flush();
        test_eu_priority();
        test_flush_inflight();
        test_consume_overlap();
        test_pc_wrap();
        test_ce_hold();
        test_reset_midtx();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nec_prefetch.md
NEC_PREFETCH -- requirements
Module: nec_prefetch

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 reset  in  1  synchronous, active-high; overrides ce.
REQ-003 ce  in  1  clock enable; with ce low, all state holds and bus_ack is ignored.
REQ-004 ps  in  16  program segment; fetch linear address = {ps,4'h0} + fetch_pc, modulo 2^20.
REQ-005 flush  in  1  discard queue, restart fetch at flush_pc.
REQ-006 flush_pc  in  16  new program counter, valid with flush.
REQ-007 consume  in  4  bytes retired by the decoder this cycle, 0..ipq_len.
REQ-008 ipq[8]  out  8 each  queue storage; byte at code offset A lives in ipq[A[2:0]].
REQ-009 ipq_len  out  4  valid bytes from head_pc, 0..8.
REQ-010 eu_req  in  1  execution-unit data access request, held until eu_ack.
REQ-011 eu_addr  in  20  EU linear byte address.
REQ-012 eu_we / eu_be / eu_wdata  in  1 / 2 / 16  EU write flag, byte lanes, write data.
REQ-013 eu_ack  out  1  one-cycle pulse when the EU access completes.
REQ-014 eu_rdata  out  16  bus_rdata captured on eu_ack.
REQ-015 bus_req  out  1  bus transaction active; held with stable address/controls until bus_ack.
REQ-016 bus_addr / bus_we / bus_be / bus_wdata  out  20 / 1 / 2 / 16  transaction controls.
REQ-017 bus_ack  in  1  one-cycle completion strobe; bus_rdata valid in the same cycle.
REQ-018 bus_rdata  in  16  read data.

Function
REQ-019 Internal head_pc (byte offset of ipq_len base) and fetch_pc; ipq_len SHALL equal fetch_pc - head_pc.
REQ-020 States: IDLE, FETCH, EU; one transaction in flight at most, never preempted.
REQ-021 IDLE: eu_req SHALL win over prefetch; enter EU and drive eu_addr/eu_we/eu_be/eu_wdata on bus the next cycle.
REQ-022 IDLE, no eu_req: start prefetch if free space (8 - ipq_len) >= 2, or >= 1 when fetch_pc is odd; else stay IDLE.
REQ-023 Prefetch: bus_we=0; even fetch_pc -> bus_be=2'b11, 2 bytes; odd fetch_pc -> bus_be=2'b10, 1 byte from bus_rdata[15:8].
REQ-024 Prefetch ack: write bytes into ipq[fetch_pc[2:0]] (and ipq[fetch_pc[2:0]+1] mod 8), fetch_pc += byte count, return IDLE.
REQ-025 EU ack: eu_ack=1 and eu_rdata=bus_rdata for one cycle, return IDLE; bus_req drops the cycle after any ack (one idle bus cycle minimum).
REQ-026 Each ce cycle: head_pc += consume; ipq_len_next = ipq_len + bytes_written - consume, both applied in the same cycle.
REQ-027 flush (ce high): head_pc = fetch_pc = flush_pc, ipq_len = 0 next cycle; consume and any write that cycle ignored.
REQ-028 flush during an in-flight prefetch: transaction completes on the bus, its data SHALL be discarded and fetch_pc not advanced.
REQ-029 flush during an EU transaction: no effect on the EU access; eu_ack still delivered.
REQ-030 fetch_pc and head_pc wrap at 16 bits (FFFF -> 0000); linear address wraps at 20 bits.
REQ-031 ipq_len SHALL never exceed 8; the free-space check of REQ-022 uses the value before the current-cycle consume.

Reset
REQ-032 On reset: state IDLE, head_pc = fetch_pc = 16'h0000, ipq_len 0, bus_req 0, bus_we 0, bus_be 0, bus_addr 0, bus_wdata 0, eu_ack 0, eu_rdata 0, pending flush-discard cleared; ipq contents undefined.
REQ-033 Reset mid-transaction abandons it; a subsequent bus_ack with no bus_req SHALL be ignored.

Verification
REQ-034 Reset, ps=FFFF, no consume, ack every 2nd cycle -> addresses FFFF0, FFFF2, FFFF4, FFFF6, stops at ipq_len=8, bus_req stays 0.
REQ-035 flush_pc=0003, ps=0000 -> first fetch bus_addr=00003, bus_be=10, ipq_len=1 and ipq[3]=rdata[15:8]; next fetch at 00004 be=11.
REQ-036 eu_req and prefetch eligible in the same IDLE cycle -> EU transaction first; eu_ack pulses 1 cycle with eu_rdata=1234; prefetch follows.
REQ-037 flush asserted while prefetch at 00010 in flight, flush_pc=0040 -> ack data dropped, ipq_len 0, next bus_addr 00040.
REQ-038 ipq_len=6, prefetch ack writing 2 bytes with consume=3 in the same cycle -> ipq_len=5, head_pc +3.
REQ-039 fetch_pc=FFFE, ps=1000 -> fetch at 1FFFE, then fetch_pc wraps to 0000, next bus_addr 10000.
